// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory fetch with a one-entry skid buffer,
// redirect handling and ECALL halt, presenting a registered instruction/PC to decode.
module instr_fetch_unit #(
    parameter int              N        = 32,
    parameter logic [N-1:0]    RESET_PC = 32'h00000000
) (
    input  logic         clk,
    input  logic         rst,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ready,
    input  logic [N-1:0] imem_rdata,
    input  logic         stall,
    input  logic         redirect,
    input  logic [N-1:0] redirect_pc,
    output logic [N-1:0] Instruction,
    output logic [N-1:0] PC_out,
    output logic         inst_valid,
    output logic         halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        SKID  = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [N-1:0] NOP        = N'(32'h00000013);
    localparam logic [N-1:0] ALIGN_MASK = ~N'(3);
    localparam logic [N-1:0] PC_STEP    = N'(4);

    state_t       state, state_next;
    logic [N-1:0] pc;
    logic [N-1:0] skid_instr;
    logic [N-1:0] skid_pc;

    logic slot_free;
    logic xfer;
    logic load_mem;
    logic load_skid;
    logic drain_skid;

    function automatic logic is_ecall(input logic [6:0] opcode);
        return opcode == 7'b1110011;
    endfunction

    // Request / handshake decode
    always_comb begin
        imem_req   = (state == FETCH);
        imem_addr  = pc & ALIGN_MASK;
        halted     = (state == HALT);
        slot_free  = !inst_valid || !stall;
        xfer       = imem_req && imem_ready;
        load_mem   = !redirect && xfer && slot_free;
        load_skid  = !redirect && xfer && !slot_free;
        drain_skid = !redirect && (state == SKID) && slot_free;
    end

    // Next-state logic; redirect wins over every other event
    always_comb begin
        state_next = state;
        if (redirect) begin
            state_next = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (load_mem)
                        state_next = is_ecall(imem_rdata[6:0]) ? HALT : FETCH;
                    else if (load_skid)
                        state_next = SKID;
                end
                SKID: begin
                    if (drain_skid)
                        state_next = is_ecall(skid_instr[6:0]) ? HALT : FETCH;
                end
                HALT:    state_next = HALT;
                default: state_next = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= FETCH;
        else
            state <= state_next;
    end

    // Fetch PC and output slot; the skid is "full" exactly while in SKID
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= RESET_PC;
            Instruction <= NOP;
            PC_out      <= '0;
            inst_valid  <= 1'b0;
        end else begin
            if (redirect)
                pc <= redirect_pc & ALIGN_MASK;
            else if (load_mem || load_skid)
                pc <= pc + PC_STEP;

            if (load_mem) begin
                Instruction <= imem_rdata;
                PC_out      <= pc;
            end else if (drain_skid) begin
                Instruction <= skid_instr;
                PC_out      <= skid_pc;
            end

            if (redirect)
                inst_valid <= 1'b0;
            else if (load_mem || drain_skid)
                inst_valid <= 1'b1;
            else if (slot_free)
                inst_valid <= 1'b0;
        end
    end

    // Skid payload carries no reset; its occupancy is tracked by the state register
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_instr <= imem_rdata;
            skid_pc    <= pc;
        end
    end

endmodule
